// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit computer: fetch in T0-T1, opcode-specific execute in T2-T4.
// Holds the step counter, the ALU flag register and the sticky halt state.
module control_sequencer #(
   parameter int MAX_STEP = 4
) (
   input  logic       clock,
   input  logic       reset_btn,
   input  logic [3:0] opcode,
   input  logic       alu_carry,
   input  logic       alu_zero,
   output logic       CO,
   output logic       CE,
   output logic       J,
   output logic       MI,
   output logic       RI,
   output logic       RO,
   output logic       II,
   output logic       IO,
   output logic       AI,
   output logic       AO,
   output logic       BI,
   output logic       EO,
   output logic       SU,
   output logic       FI,
   output logic       OI,
   output logic       HLT,
   output logic [2:0] step,
   output logic       flag_c,
   output logic       flag_z
);

   typedef enum logic {
      RUNNING = 1'b0,
      HALTED  = 1'b1
   } run_state_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_LDA = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_STA = 4'd4,
      OP_LDI = 4'd5,
      OP_JMP = 4'd6,
      OP_JC  = 4'd7,
      OP_JZ  = 4'd8,
      OP_OUT = 4'd14,
      OP_HLT = 4'd15
   } opcode_t;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;

   run_state_t run_state, run_state_d;
   logic [2:0] step_q, step_d;
   logic       flag_c_q, flag_c_d;
   logic       flag_z_q, flag_z_d;
   logic       last_step;

   always_ff @(posedge clock or negedge reset_btn) begin
      if (!reset_btn) begin
         run_state <= RUNNING;
         step_q    <= T0;
         flag_c_q  <= 1'b0;
         flag_z_q  <= 1'b0;
      end else begin
         run_state <= run_state_d;
         step_q    <= step_d;
         flag_c_q  <= flag_c_d;
         flag_z_q  <= flag_z_d;
      end
   end

   // Control decode and next state; everything stays zero while the reset button is held.
   always_comb begin
      CO = 1'b0; CE = 1'b0; J  = 1'b0; MI = 1'b0;
      RI = 1'b0; RO = 1'b0; II = 1'b0; IO = 1'b0;
      AI = 1'b0; AO = 1'b0; BI = 1'b0; EO = 1'b0;
      SU = 1'b0; FI = 1'b0; OI = 1'b0; HLT = 1'b0;
      last_step   = 1'b0;
      run_state_d = run_state;
      step_d      = step_q;
      flag_c_d    = flag_c_q;
      flag_z_d    = flag_z_q;

      if (reset_btn && run_state == HALTED) begin
         HLT = 1'b1;
      end else if (reset_btn) begin
         case (step_q)
            T0: begin
               CO = 1'b1; MI = 1'b1;
            end
            T1: begin
               RO = 1'b1; II = 1'b1; CE = 1'b1;
            end
            T2: begin
               last_step = 1'b1;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     IO = 1'b1; MI = 1'b1; last_step = 1'b0;
                  end
                  OP_LDI: begin
                     IO = 1'b1; AI = 1'b1;
                  end
                  OP_JMP: begin
                     IO = 1'b1; J = 1'b1;
                  end
                  OP_JC: begin
                     IO = flag_c_q; J = flag_c_q;
                  end
                  OP_JZ: begin
                     IO = flag_z_q; J = flag_z_q;
                  end
                  OP_OUT: begin
                     AO = 1'b1; OI = 1'b1;
                  end
                  OP_HLT: begin
                     HLT = 1'b1;
                  end
                  default: ;
               endcase
            end
            T3: begin
               last_step = 1'b1;
               case (opcode)
                  OP_LDA: begin
                     RO = 1'b1; AI = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     RO = 1'b1; BI = 1'b1; last_step = 1'b0;
                  end
                  OP_STA: begin
                     AO = 1'b1; RI = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               last_step = 1'b1;
               case (opcode)
                  OP_ADD: begin
                     EO = 1'b1; AI = 1'b1; FI = 1'b1;
                  end
                  OP_SUB: begin
                     EO = 1'b1; AI = 1'b1; SU = 1'b1; FI = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase

         // HLT keeps the counter parked on T2 so the frozen step is visible on the debug port.
         if (HLT) begin
            run_state_d = HALTED;
         end else if (last_step || step_q >= 3'(MAX_STEP)) begin
            step_d = T0;
         end else begin
            step_d = step_q + 3'd1;
         end

         if (FI) begin
            flag_c_d = alu_carry;
            flag_z_d = alu_zero;
         end
      end
   end

   assign step   = step_q;
   assign flag_c = flag_c_q;
   assign flag_z = flag_z_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected control words go through a scoreboard queue.
// Expected words come from an instruction table and a bench-side flag model.
module tb_control_sequencer;

   logic       clock = 1'b0;
   logic       reset_btn;
   logic [3:0] opcode;
   logic       alu_carry;
   logic       alu_zero;
   logic       CO, CE, J, MI, RI, RO, II, IO;
   logic       AI, AO, BI, EO, SU, FI, OI, HLT;
   logic [2:0] step;
   logic       flag_c, flag_z;

   int   testsRun = 0;
   int   testsFailed = 0;
   logic expC, expZ;

   typedef struct {
      string       tag;
      logic [20:0] val;
   } expect_t;
   expect_t scoreboard[$];

   localparam logic [15:0] C_CO  = 16'h8000;
   localparam logic [15:0] C_CE  = 16'h4000;
   localparam logic [15:0] C_J   = 16'h2000;
   localparam logic [15:0] C_MI  = 16'h1000;
   localparam logic [15:0] C_RI  = 16'h0800;
   localparam logic [15:0] C_RO  = 16'h0400;
   localparam logic [15:0] C_II  = 16'h0200;
   localparam logic [15:0] C_IO  = 16'h0100;
   localparam logic [15:0] C_AI  = 16'h0080;
   localparam logic [15:0] C_AO  = 16'h0040;
   localparam logic [15:0] C_BI  = 16'h0020;
   localparam logic [15:0] C_EO  = 16'h0010;
   localparam logic [15:0] C_SU  = 16'h0008;
   localparam logic [15:0] C_FI  = 16'h0004;
   localparam logic [15:0] C_OI  = 16'h0002;
   localparam logic [15:0] C_HLT = 16'h0001;

   control_sequencer #(.MAX_STEP(4)) dut (
      .clock(clock), .reset_btn(reset_btn), .opcode(opcode),
      .alu_carry(alu_carry), .alu_zero(alu_zero),
      .CO(CO), .CE(CE), .J(J), .MI(MI), .RI(RI), .RO(RO), .II(II), .IO(IO),
      .AI(AI), .AO(AO), .BI(BI), .EO(EO), .SU(SU), .FI(FI), .OI(OI), .HLT(HLT),
      .step(step), .flag_c(flag_c), .flag_z(flag_z)
   );

   always #5 clock = ~clock;

   function automatic int instrLen(input logic [3:0] op);
      case (op)
         4'd2, 4'd3: return 5;
         4'd1, 4'd4: return 4;
         default:    return 3;
      endcase
   endfunction

   function automatic logic [15:0] expCtrl(input logic [3:0] op, input int t, input logic fc, input logic fz);
      if (t == 0) return C_CO | C_MI;
      if (t == 1) return C_RO | C_II | C_CE;
      if (t == 2) begin
         case (op)
            4'd1, 4'd2, 4'd3, 4'd4: return C_IO | C_MI;
            4'd5:  return C_IO | C_AI;
            4'd6:  return C_IO | C_J;
            4'd7:  return fc ? (C_IO | C_J) : 16'h0000;
            4'd8:  return fz ? (C_IO | C_J) : 16'h0000;
            4'd14: return C_AO | C_OI;
            4'd15: return C_HLT;
            default: return 16'h0000;
         endcase
      end
      if (t == 3) begin
         case (op)
            4'd1:       return C_RO | C_AI;
            4'd2, 4'd3: return C_RO | C_BI;
            4'd4:       return C_AO | C_RI;
            default:    return 16'h0000;
         endcase
      end
      case (op)
         4'd2:    return C_EO | C_AI | C_FI;
         4'd3:    return C_EO | C_AI | C_SU | C_FI;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic pushExpect(input string tag, input logic [15:0] ctrl, input logic [2:0] st);
      expect_t e;
      e.tag = tag;
      e.val = {ctrl, st, expC, expZ};
      scoreboard.push_back(e);
   endtask

   task automatic applyStimulus(input logic rst, input logic [3:0] op, input logic c, input logic z,
                                input string tag, input logic [15:0] ctrl, input logic [2:0] st);
      @(negedge clock);
      reset_btn = rst;
      opcode    = op;
      alu_carry = c;
      alu_zero  = z;
      #1;
      pushExpect(tag, ctrl, st);
   endtask

   task automatic checkOutput();
      expect_t     e;
      logic [20:0] obs;
      e   = scoreboard.pop_front();
      obs = {CO, CE, J, MI, RI, RO, II, IO, AI, AO, BI, EO, SU, FI, OI, HLT, step, flag_c, flag_z};
      testsRun++;
      assert (obs === e.val) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
   endtask

   // Runs steps first..last of one instruction, updating the flag model after an FI cycle.
   task automatic runInstr(input logic [3:0] op, input logic c, input logic z,
                           input int first, input int last, input string tag);
      logic [15:0] ctrl;
      for (int t = first; t <= last; t++) begin
         ctrl = expCtrl(op, t, expC, expZ);
         applyStimulus(1'b1, op, c, z, $sformatf("%s T%0d", tag, t), ctrl, 3'(t));
         checkOutput();
         if ((ctrl & C_FI) != 16'h0000) begin
            expC = c;
            expZ = z;
         end
      end
   endtask

   task automatic fullInstr(input logic [3:0] op, input logic c, input logic z, input string tag);
      runInstr(op, c, z, 0, instrLen(op) - 1, tag);
   endtask

   // Drops reset between clock edges and checks that outputs and state clear without an edge.
   task automatic asyncReset(input string tag);
      #1;
      reset_btn = 1'b0;
      #1;
      expC = 1'b0;
      expZ = 1'b0;
      pushExpect(tag, 16'h0000, 3'd0);
      checkOutput();
   endtask

   initial begin
      reset_btn = 1'b0;
      opcode    = 4'd0;
      alu_carry = 1'b0;
      alu_zero  = 1'b0;
      expC      = 1'b0;
      expZ      = 1'b0;

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, "reset hold", 16'h0000, 3'd0);
         checkOutput();
      end
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, "release T0", C_CO | C_MI, 3'd0);
      checkOutput();
      runInstr(4'd0, 1'b0, 1'b0, 1, 2, "nop");
      fullInstr(4'd0, 1'b1, 1'b1, "nop period");

      fullInstr(4'd2, 1'b1, 1'b0, "add c1z0");
      fullInstr(4'd3, 1'b1, 1'b1, "sub to zero");
      fullInstr(4'd8, 1'b0, 1'b0, "jz taken");
      fullInstr(4'd2, 1'b0, 1'b0, "add c0z0");
      fullInstr(4'd8, 1'b1, 1'b1, "jz not taken");
      fullInstr(4'd7, 1'b1, 1'b1, "jc not taken");
      fullInstr(4'd1, 1'b1, 1'b1, "lda");
      fullInstr(4'd4, 1'b0, 1'b1, "sta");
      fullInstr(4'd5, 1'b1, 1'b0, "ldi");
      fullInstr(4'd6, 1'b0, 1'b1, "jmp");
      fullInstr(4'd14, 1'b1, 1'b1, "out");
      fullInstr(4'd2, 1'b1, 1'b1, "add c1z1");
      fullInstr(4'd7, 1'b0, 1'b0, "jc taken");
      fullInstr(4'd11, 1'b0, 1'b0, "undef 11");
      fullInstr(4'd9, 1'b1, 1'b0, "undef 9");
      fullInstr(4'd13, 1'b0, 1'b1, "undef 13");
      fullInstr(4'd3, 1'b0, 1'b1, "sub c0z1");

      fullInstr(4'd15, 1'b0, 1'b0, "hlt");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, $sformatf("halted %0d", i), C_HLT, 3'd2);
         checkOutput();
      end
      asyncReset("reset clears halt");

      applyStimulus(1'b0, 4'd11, 1'b0, 1'b0, "reset after halt", 16'h0000, 3'd0);
      checkOutput();
      applyStimulus(1'b1, 4'd11, 1'b0, 1'b0, "release2 T0", C_CO | C_MI, 3'd0);
      checkOutput();
      runInstr(4'd11, 1'b0, 1'b0, 1, 2, "undef after reset");
      fullInstr(4'd0, 1'b0, 1'b0, "nop after undef");

      fullInstr(4'd2, 1'b1, 1'b1, "add set flags");
      runInstr(4'd2, 1'b0, 1'b0, 0, 3, "add interrupted");
      asyncReset("reset mid add");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit computer; drives every control line on the shared bus: program counter, MAR, RAM, instruction register, A/B/ALU, output register.
- Runs a fixed fetch (T0–T1) followed by an opcode-specific execute phase (T2–T4).
- Holds the ALU flag register and the sticky halt state.

Parameters:
- MAX_STEP, 4, index of the last microstep (T0..T4).

Ports:
- clock  in  1  system clock, rising edge
- reset_btn  in  1  asynchronous active-low reset
- opcode  in  4  instruction register upper nibble
- alu_carry  in  1  ALU carry-out, valid during EO
- alu_zero  in  1  ALU result==0, valid during EO
- CO, CE, J  out  1 each  PC out / count enable / PC load (jump)
- MI, RI, RO  out  1 each  MAR in / RAM in / RAM out
- II, IO  out  1 each  IR in / IR operand nibble out
- AI, AO, BI, EO, SU, FI  out  1 each  A in/out, B in, ALU out, subtract, flags in
- OI  out  1  output register in
- HLT  out  1  halt clock
- step  out  3  current microstep, debug
- flag_c, flag_z  out  1 each  registered flags

Behaviour:
- State consists of:
  - step counter (3 bits)
  - flag_c and flag_z
  - halted bit
- All state updates on the rising clock edge.
- Control outputs are combinational decodes of (step, opcode, flag_c, flag_z, halted). They are valid for the whole cycle, and the datapath samples them at the next rising edge.

Reset:
- reset_btn=0 asynchronously clears step=0, flags=0 and halted=0.
- While reset_btn=0, all control outputs are forced to 0, including HLT.
- After release, the first cycle decodes as T0.

Fetch, identical for all opcodes:
- T0: CO MI
- T1: RO II CE
- The opcode is not valid until T2, so no opcode-dependent decision is made before T2.

Execute (steps not listed drive all zeros):
- 0 NOP: T2 empty.
- 1 LDA: T2 IO MI; T3 RO AI.
- 2 ADD: T2 IO MI; T3 RO BI; T4 EO AI FI.
- 3 SUB: T2 IO MI; T3 RO BI; T4 EO AI SU FI.
- 4 STA: T2 IO MI; T3 AO RI.
- 5 LDI: T2 IO AI.
- 6 JMP: T2 IO J.
- 7 JC: T2 IO J only if flag_c=1, otherwise T2 empty.
- 8 JZ: T2 IO J only if flag_z=1, otherwise T2 empty.
- 14 OUT: T2 AO OI.
- 15 HLT: T2 HLT.
- 9–13: undefined, executed as NOP.

Step counter:
- Early termination: the counter returns to 0 on the edge ending the opcode's last step.
- Last step per opcode:
  - T2 for NOP, LDI, JMP, JC, JZ, OUT, HLT and undefined opcodes
  - T3 for LDA and STA
  - T4 for ADD and SUB
- Instruction length in cycles: 3 / 4 / 5 respectively.
- Step never exceeds MAX_STEP. If step>MAX_STEP ever occurs, it wraps to 0 on the next edge.

Flags:
- flag_c <= alu_carry and flag_z <= alu_zero on any edge where FI=1.
- Otherwise both flags hold.
- JC/JZ evaluate the registered flags, i.e. those from the most recent ADD/SUB.

Halt:
- The edge ending HLT's T2 sets halted=1.
- While halted:
  - HLT=1
  - all other controls 0
  - step frozen at 2
  - flags hold
- Only reset clears halted.

Opcode changes mid-instruction:
- Not expected, since IR loads only at T1.
- The decode always uses the current opcode input; no internal latch.

Test Plan:
- Reset and fetch: hold reset_btn=0, then release with opcode=0 → reset cycle: all outputs 0. T0: CO=MI=1. T1: RO=II=CE=1. T2: all 0. Next cycle step=0 (period 3).
- ADD timing: opcode=2, alu_carry=1, alu_zero=0 → T2 IO MI; T3 RO BI; T4 EO AI FI with SU=0. After the T4 edge, flag_c=1, flag_z=0 and step=0.
- SUB to zero, then JZ: opcode=3 with alu_zero=1, alu_carry=1 → SU=1 at T4, flags become 1/1. Then opcode=8 → J=1 and IO=1 at T2. Repeat with flag_z=0 (via an ADD with alu_zero=0) → J=0 at T2.
- JC not taken, LDA/STA lengths: flag_c=0, opcode=7 → T2 all zero, 3-cycle instruction. opcode=1 → RO AI at T3, returns to T0 after 4 cycles. opcode=4 → AO RI at T3, 4 cycles.
- HLT sticky: opcode=15 → HLT=1 at T2. Over the following 10 cycles, HLT=1, step=2 and all other outputs stay 0 even with opcode changed to 2. Asserting reset_btn=0 clears HLT immediately, without waiting for a clock.
- Undefined opcode and async reset mid-instruction: opcode=11 → behaves as NOP (3 cycles, T2 empty). During ADD T3, assert reset_btn=0 between edges → outputs drop to 0 at once, and step=0 and flags=0 without a clock edge.
